// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: pops the async FIFO into a 2-entry skid buffer, presents a valid/ready stream with m_last framing.
// Optional FIFO_RD_STATS_EN adds saturating transfer/stall counters (stat_words, stat_stall).
module fifo_rd_stream #(
  parameter int DATASIZE  = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNTSIZE   = 16
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [DATASIZE-1:0] fifo_rdata,
  output logic                fifo_rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_last
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CNTSIZE-1:0]  stat_words,
  output logic [CNTSIZE-1:0]  stat_stall
`endif
);

  localparam logic [CNTSIZE-1:0] BEAT_MAX = CNTSIZE'(FRAME_LEN - 1);

  logic [1:0]          cnt, cnt_next, tail_idx;
  logic [DATASIZE-1:0] data0, data1, data0_next, data1_next;
  logic                last0, last1, last0_next, last1_next;
  logic [CNTSIZE-1:0]  beat, beat_next;
  logic                pop, xfer, last_tag;

  // Pop depends only on buffer occupancy, never on m_ready.
  assign pop       = enable & ~fifo_empty & (cnt < 2'd2) & ~rrst;
  assign fifo_rinc = pop;
  assign xfer      = m_valid & m_ready;
  assign last_tag  = (beat == BEAT_MAX);
  assign tail_idx  = xfer ? (cnt - 2'd1) : cnt;

  assign m_valid = (cnt != 2'd0);
  assign m_data  = data0;
  assign m_last  = last0;

  always_comb begin
    data0_next = data0;
    last0_next = last0;
    data1_next = data1;
    last1_next = last1;
    if (xfer) begin
      data0_next = data1;
      last0_next = last1;
      data1_next = '0;
      last1_next = 1'b0;
    end
    // Tail slot is computed after the shift so pop+xfer at cnt=1 refills entry 0.
    if (pop) begin
      if (tail_idx == 2'd0) begin
        data0_next = fifo_rdata;
        last0_next = last_tag;
      end else begin
        data1_next = fifo_rdata;
        last1_next = last_tag;
      end
    end
    cnt_next = cnt + {1'b0, pop} - {1'b0, xfer};
  end

  always_comb begin
    beat_next = beat;
    if (pop) begin
      beat_next = last_tag ? '0 : beat + CNTSIZE'(1);
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      cnt   <= 2'd0;
      data0 <= '0;
      data1 <= '0;
      last0 <= 1'b0;
      last1 <= 1'b0;
      beat  <= '0;
    end else begin
      cnt   <= cnt_next;
      data0 <= data0_next;
      data1 <= data1_next;
      last0 <= last0_next;
      last1 <= last1_next;
      beat  <= beat_next;
    end
  end

`ifdef FIFO_RD_STATS_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (xfer && (stat_words != '1)) begin
        stat_words <= stat_words + CNTSIZE'(1);
      end
      if (m_valid && !m_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + CNTSIZE'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: queue-based reference model plus directed literal checks and random traffic.
module tb_fifo_rd_stream;
  localparam int DW = 8;
  localparam int FL = 16;
  localparam int CW = 16;

  logic          rclk = 1'b0;
  logic          rrst, enable, fifo_empty, m_ready;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rinc, m_valid, m_last;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] stat_words, stat_stall;
`endif

  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DATASIZE(DW), .FRAME_LEN(FL), .CNTSIZE(CW)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .fifo_rinc  (fifo_rinc),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
`ifdef FIFO_RD_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  beat_t         mq[$];
  beat_t         obs[$];
  logic [DW-1:0] fq[$];
  int unsigned   pops_since_rst;
  int unsigned   exp_words, exp_stall;
  bit            force_empty;
  int            rinc_seen;
  int            n_checks, n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic load(input int n, input int start);
    for (int i = 0; i < n; i++) fq.push_back(DW'(start + i));
  endtask

  // One cycle: present inputs, compare against the model, clock, advance the model.
  task automatic step();
    bit    exp_rinc, exp_valid, do_xfer;
    beat_t b;
    fifo_empty = force_empty || (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : 8'hA5;
    #1;
    exp_rinc  = enable && !fifo_empty && (mq.size() < 2) && !rrst;
    exp_valid = (mq.size() != 0);
    chk("fifo_rinc", fifo_rinc, exp_rinc);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) begin
      chk("m_data", m_data, mq[0].d);
      chk("m_last", m_last, mq[0].l);
    end
`ifdef FIFO_RD_STATS_EN
    chk("stat_words", stat_words, exp_words);
    chk("stat_stall", stat_stall, exp_stall);
`endif
    do_xfer = exp_valid && m_ready;
    if (!rrst && m_valid && m_ready) obs.push_back(beat_t'({m_data, m_last}));
    if (fifo_rinc) rinc_seen++;
    @(posedge rclk);
    if (rrst) begin
      mq.delete();
      pops_since_rst = 0;
      exp_words = 0;
      exp_stall = 0;
    end else begin
      if (exp_valid && !m_ready && exp_stall != 65535) exp_stall++;
      if (do_xfer) begin
        void'(mq.pop_front());
        if (exp_words != 65535) exp_words++;
      end
      if (exp_rinc) begin
        b.d = fq[0];
        b.l = ((pops_since_rst % FL) == FL - 1);
        mq.push_back(b);
        pops_since_rst++;
        void'(fq.pop_front());
      end
    end
    #2;
  endtask

  task automatic do_reset(input int n);
    rrst = 1'b1;
    repeat (n) step();
    rrst = 1'b0;
  endtask

  initial begin
    int bad, nlast;
    n_checks = 0; n_pass = 0; rinc_seen = 0;
    pops_since_rst = 0; exp_words = 0; exp_stall = 0;
    enable = 1'b1; m_ready = 1'b0; force_empty = 1'b0;
    fifo_empty = 1'b1; fifo_rdata = '0;
    rrst = 1'b1;
    @(posedge rclk); #2;

    // Reset then idle
    fq.delete(); load(4, 1);
    rrst = 1'b1; step(); step();
    chk("rst_rinc", fifo_rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    rrst = 1'b0; rinc_seen = 0;
    step();
    chk("first_pop", rinc_seen, 1);
    chk("first_data", m_data, 8'h01);
    chk("first_valid", m_valid, 1);

    // Streaming 0x01..0x20 at one beat per cycle
    fq.delete(); do_reset(2);
    load(32, 1); m_ready = 1'b1; obs.delete();
    repeat (33) step();
    chk("stream_count", obs.size(), 32);
    bad = 0; nlast = 0;
    foreach (obs[i]) begin
      if (obs[i].d != DW'(i + 1) || obs[i].l != (((i + 1) % 16) == 0)) bad++;
      if (obs[i].l) nlast++;
    end
    chk("stream_order_last", bad, 0);
    chk("stream_last_cnt", nlast, 2);

    // Backpressure
    fq.delete(); do_reset(1);
    load(8, 1); m_ready = 1'b0; rinc_seen = 0;
    repeat (5) step();
    chk("bp_pops", rinc_seen, 2);
    chk("bp_hold_data", m_data, 8'h01);
    chk("bp_rinc_off", fifo_rinc, 0);
    m_ready = 1'b1; obs.delete();
    repeat (3) step();
    chk("bp_count", obs.size(), 3);
    foreach (obs[i]) chk("bp_seq", obs[i].d, DW'(i + 1));

    // Empty boundary
    fq.delete(); do_reset(1);
    load(3, 'h40); m_ready = 1'b1; rinc_seen = 0; obs.delete();
    repeat (8) step();
    chk("empty_pops", rinc_seen, 3);
    chk("empty_xfers", obs.size(), 3);
    chk("empty_valid", m_valid, 0);
    chk("empty_rinc", fifo_rinc, 0);

    // Enable pause after beat 5, then resume the same frame
    fq.delete(); do_reset(1);
    load(40, 'h80); m_ready = 1'b1; enable = 1'b1; rinc_seen = 0; obs.delete();
    for (int i = 0; i < 20 && rinc_seen < 6; i++) step();
    enable = 1'b0;
    repeat (4) step();
    chk("pause_pops", rinc_seen, 6);
    chk("pause_drained", m_valid, 0);
    enable = 1'b1;
    repeat (20) step();
    chk("pause_xfers_ge16", obs.size() >= 16, 1);
    if (obs.size() >= 16) begin
      nlast = 0;
      for (int i = 0; i < 15; i++) if (obs[i].l) nlast++;
      chk("pause_no_early_last", nlast, 0);
      chk("pause_last_beat15", obs[15].l, 1);
      chk("pause_last_data", obs[15].d, 8'h8F);
    end

    // Reset mid-operation with cnt=2, beat=9
    fq.delete(); do_reset(1);
    load(60, 'h10); m_ready = 1'b1; rinc_seen = 0;
    repeat (8) step();
    m_ready = 1'b0;
    step(); step();
    chk("midrst_pops", rinc_seen, 9);
    chk("midrst_full_valid", m_valid, 1);
    rrst = 1'b1; step(); rrst = 1'b0;
    chk("midrst_valid", m_valid, 0);
    obs.delete();
    m_ready = 1'b0; repeat (4) step();
    m_ready = 1'b1; repeat (4) step();
`ifdef FIFO_RD_STATS_EN
    chk("stat_stall_lit", stat_stall, 3);
    chk("stat_words_lit", stat_words, 4);
`endif
    repeat (16) step();
    chk("midrst_xfers_ge16", obs.size() >= 16, 1);
    if (obs.size() >= 16) begin
      nlast = 0;
      for (int i = 0; i < 15; i++) if (obs[i].l) nlast++;
      chk("midrst_no_early_last", nlast, 0);
      chk("midrst_last", obs[15].l, 1);
      chk("midrst_last_data", obs[15].d, 8'h28);
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      enable      = ($urandom_range(0, 9) != 0);
      m_ready     = ($urandom_range(0, 3) != 0);
      force_empty = ($urandom_range(0, 7) == 0);
      rrst        = ($urandom_range(0, 199) == 0);
      if (fq.size() < 4) load($urandom_range(1, 20), $urandom_range(0, 255));
      step();
    end
    rrst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
